// File: rtl/ccip_host_mem_model.sv
// Host-side CCI-P memory model: services AFU c0 reads and c1 writes/fences
// from an internal line memory and returns in-order c0Rx/c1Rx responses.
module ccip_host_mem_model #(
  parameter int unsigned MEM_LINES_LOG2 = 10,
  parameter int unsigned RD_LATENCY     = 4,
  parameter int unsigned RSP_FIFO_DEPTH = 16,
  parameter int unsigned ALMFULL_SLACK  = 4
) (
  input  logic         pClk,
  input  logic         pck_cp2af_softReset_n,
  input  logic [73:0]  c0Tx_hdr,
  input  logic         c0Tx_valid,
  input  logic [79:0]  c1Tx_hdr,
  input  logic [511:0] c1Tx_data,
  input  logic         c1Tx_valid,
  input  logic         c0_throttle,
  input  logic         c1_throttle,
  output logic         c0TxAlmFull,
  output logic         c1TxAlmFull,
  output logic [27:0]  c0Rx_hdr,
  output logic [511:0] c0Rx_data,
  output logic         c0Rx_rspValid,
  output logic [27:0]  c1Rx_hdr,
  output logic         c1Rx_rspValid,
  output logic [3:0]   err_status
);

  localparam int unsigned MEM_LINES = 32'd1 << MEM_LINES_LOG2;
  localparam int unsigned LINE_W    = 512;
  localparam int unsigned MD_W      = 16;
  localparam int unsigned PTR_W     = $clog2(RSP_FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned AF_THR    = RSP_FIFO_DEPTH - ALMFULL_SLACK;

  localparam logic [3:0] REQ_LINE_I = 4'h0;
  localparam logic [3:0] REQ_LINE_S = 4'h1;
  localparam logic [3:0] REQ_FENCE  = 4'h4;
  localparam logic [3:0] RSP_RD     = 4'h0;
  localparam logic [3:0] RSP_WR     = 4'h1;
  localparam logic [3:0] RSP_FENCE  = 4'h4;

  logic [LINE_W-1:0] mem [MEM_LINES];

  // c0 request decode
  logic [3:0]                c0_type;
  logic [MEM_LINES_LOG2-1:0] c0_idx;
  logic                      c0_acc;
  logic                      c0_bad_type;
  logic                      c0_len_err;
  logic                      c0_pop;
  logic                      c0_ovf;
  logic                      c0_rq;
  logic [LINE_W-1:0]         c0_rd_line;
  logic [CNT_W-1:0]          c0_cnt;
  logic [CNT_W-1:0]          c0_inflight;
  logic [CNT_W-1:0]          c0_occ;
  logic                      c0_push;
  logic [MD_W-1:0]           c0_push_md;
  logic [LINE_W-1:0]         c0_push_dat;
  logic [PTR_W-1:0]          c0_wp;
  logic [PTR_W-1:0]          c0_rp;
  logic [MD_W-1:0]           c0_fmd  [RSP_FIFO_DEPTH];
  logic [LINE_W-1:0]         c0_fdat [RSP_FIFO_DEPTH];

  // c1 request decode
  logic [3:0]                c1_type;
  logic [MEM_LINES_LOG2-1:0] c1_idx;
  logic                      c1_wr;
  logic                      c1_fence;
  logic                      c1_acc;
  logic                      c1_bad_type;
  logic                      c1_len_err;
  logic                      c1_pop;
  logic                      c1_ovf;
  logic                      c1_push;
  logic [CNT_W-1:0]          c1_cnt;
  logic [PTR_W-1:0]          c1_wp;
  logic [PTR_W-1:0]          c1_rp;
  logic [3:0]                c1_ftyp [RSP_FIFO_DEPTH];
  logic [MD_W-1:0]           c1_fmd  [RSP_FIFO_DEPTH];

  logic unused_hdr;
  assign unused_hdr = ^{c0Tx_hdr, c1Tx_hdr};

  // Request classification, overflow detection and occupancy
  always_comb begin
    c0_type     = c0Tx_hdr[67:64];
    c0_idx      = c0Tx_hdr[16 +: MEM_LINES_LOG2];
    c0_acc      = c0Tx_valid && (c0_type == REQ_LINE_I || c0_type == REQ_LINE_S);
    c0_bad_type = c0Tx_valid && !c0_acc;
    c0_len_err  = c0_acc && (c0Tx_hdr[69:68] != 2'b00);
    c0_occ      = c0_cnt + c0_inflight;
    c0_pop      = (c0_cnt != '0) && !c0_throttle;
    // A pop in the same cycle frees the slot, so only a full channel without a pop overflows
    c0_ovf      = c0_acc && (c0_occ == CNT_W'(RSP_FIFO_DEPTH)) && !c0_pop;
    c0_rq       = c0_acc && !c0_ovf;
    c0_rd_line  = mem[c0_idx];

    c1_type     = c1Tx_hdr[67:64];
    c1_idx      = c1Tx_hdr[16 +: MEM_LINES_LOG2];
    c1_wr       = c1Tx_valid && (c1_type == REQ_LINE_I || c1_type == REQ_LINE_S);
    c1_fence    = c1Tx_valid && (c1_type == REQ_FENCE);
    c1_acc      = c1_wr || c1_fence;
    c1_bad_type = c1Tx_valid && !c1_acc;
    c1_len_err  = c1_acc && (c1Tx_hdr[69:68] != 2'b00);
    c1_pop      = (c1_cnt != '0) && !c1_throttle;
    c1_ovf      = c1_acc && (c1_cnt == CNT_W'(RSP_FIFO_DEPTH)) && !c1_pop;
    c1_push     = c1_acc && !c1_ovf;
  end

  // Line memory: not reset so contents survive a soft reset; reads see pre-edge data
  always_ff @(posedge pClk) begin
    if (c1_wr) mem[c1_idx] <= c1Tx_data;
  end

  // Read pipeline: the FIFO push edge is the last of RD_LATENCY stages
  generate
    if (RD_LATENCY > 1) begin : g_pipe
      localparam int unsigned NSTG = RD_LATENCY - 1;
      logic [NSTG-1:0]   vld;
      logic [MD_W-1:0]   md  [NSTG];
      logic [LINE_W-1:0] dat [NSTG];

      // Stage valids, flushed on reset so in-flight reads are discarded
      always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
          vld <= '0;
        end else begin
          vld[0] <= c0_rq;
          for (int i = 1; i < NSTG; i++) vld[i] <= vld[i-1];
        end
      end

      // Stage payloads follow their valids
      always_ff @(posedge pClk) begin
        md[0]  <= c0Tx_hdr[15:0];
        dat[0] <= c0_rd_line;
        for (int i = 1; i < NSTG; i++) begin
          md[i]  <= md[i-1];
          dat[i] <= dat[i-1];
        end
      end

      // Count responses still in the pipeline
      always_comb begin
        c0_inflight = '0;
        for (int i = 0; i < NSTG; i++) c0_inflight = c0_inflight + CNT_W'(vld[i]);
      end

      assign c0_push     = vld[NSTG-1];
      assign c0_push_md  = md[NSTG-1];
      assign c0_push_dat = dat[NSTG-1];
    end else begin : g_nopipe
      assign c0_push     = c0_rq;
      assign c0_push_md  = c0Tx_hdr[15:0];
      assign c0_push_dat = c0_rd_line;
      assign c0_inflight = '0;
    end
  endgenerate

  // Response FIFO storage
  always_ff @(posedge pClk) begin
    if (c0_push) begin
      c0_fmd[c0_wp]  <= c0_push_md;
      c0_fdat[c0_wp] <= c0_push_dat;
    end
    if (c1_push) begin
      c1_ftyp[c1_wp] <= c1_fence ? RSP_FENCE : RSP_WR;
      c1_fmd[c1_wp]  <= c1Tx_hdr[15:0];
    end
  end

  // c0 FIFO control, registered delivery and almost-full
  always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
    if (!pck_cp2af_softReset_n) begin
      c0_wp         <= '0;
      c0_rp         <= '0;
      c0_cnt        <= '0;
      c0Rx_rspValid <= 1'b0;
      c0Rx_hdr      <= '0;
      c0Rx_data     <= '0;
      c0TxAlmFull   <= 1'b0;
    end else begin
      if (c0_push) c0_wp <= c0_wp + PTR_W'(1);
      if (c0_pop)  c0_rp <= c0_rp + PTR_W'(1);
      c0_cnt        <= c0_cnt + CNT_W'(c0_push) - CNT_W'(c0_pop);
      c0Rx_rspValid <= c0_pop;
      if (c0_pop) begin
        c0Rx_hdr  <= {6'b0, 2'b00, RSP_RD, c0_fmd[c0_rp]};
        c0Rx_data <= c0_fdat[c0_rp];
      end
      c0TxAlmFull <= (c0_occ >= CNT_W'(AF_THR));
    end
  end

  // c1 FIFO control, registered delivery and almost-full
  always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
    if (!pck_cp2af_softReset_n) begin
      c1_wp         <= '0;
      c1_rp         <= '0;
      c1_cnt        <= '0;
      c1Rx_rspValid <= 1'b0;
      c1Rx_hdr      <= '0;
      c1TxAlmFull   <= 1'b0;
    end else begin
      if (c1_push) c1_wp <= c1_wp + PTR_W'(1);
      if (c1_pop)  c1_rp <= c1_rp + PTR_W'(1);
      c1_cnt        <= c1_cnt + CNT_W'(c1_push) - CNT_W'(c1_pop);
      c1Rx_rspValid <= c1_pop;
      if (c1_pop) c1Rx_hdr <= {6'b0, 2'b00, c1_ftyp[c1_rp], c1_fmd[c1_rp]};
      c1TxAlmFull <= (c1_cnt >= CNT_W'(AF_THR));
    end
  end

  // Sticky error flags
  always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
    if (!pck_cp2af_softReset_n) begin
      err_status <= '0;
    end else begin
      err_status <= err_status | {c0_bad_type || c1_bad_type,
                                  c0_len_err || c1_len_err,
                                  c1_ovf,
                                  c0_ovf};
    end
  end

endmodule
